fb_responder: RTL and testbench



---
 rtl/fb_responder.sv | 160 ++++++++++++++++
 tb/tb_fb_responder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_responder.sv
// Framebuffer responder: arbitrates write words and read requests onto one single-port RAM
// and streams read data through a skid buffer. Define FB_RESP_CLEAR_EN to zero the RAM after reset.
//
// Clear sequencer (FB_RESP_CLEAR_EN only)
//   state    | meaning
//   ST_SWEEP | writing zero to RAM index sweep_idx, init_done low
//   ST_READY | sweep finished, requests are served
module fb_responder #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MEM_AW     = 16,
    parameter int SKID_DEPTH = 4,
    parameter int STARVE_LIM = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     wr_ren,
    input  logic [ADDR_W+DATA_W-1:0] wr_rd,
    input  logic                     wr_empty,
    output logic                     addr_ren,
    input  logic [ADDR_W-1:0]        addr_rd,
    input  logic                     addr_empty,
    output logic                     data_wen,
    output logic [DATA_W-1:0]        data_wd,
    input  logic                     data_full,
    output logic                     init_done
);

    localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int CNT_W = $clog2(SKID_DEPTH + 1);
    localparam int OCC_W = $clog2(SKID_DEPTH + 3);
    localparam int STK_W = $clog2(STARVE_LIM + 1);

    logic [DATA_W-1:0] mem [2**MEM_AW];
    logic [DATA_W-1:0] ram_q;
    logic              ram_we;
    logic [MEM_AW-1:0] ram_idx;
    logic [DATA_W-1:0] ram_wdata;

    logic              wr_v1, rd_v1, rd_v2;
    logic [STK_W-1:0]  rd_streak;
    logic              ready;
    logic              sweep_we;
    logic [MEM_AW-1:0] sweep_idx;

    logic [DATA_W-1:0] skid_mem [SKID_DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  skid_cnt;
    logic [OCC_W-1:0]  occ;
    logic              rd_elig, wr_elig, grant_rd, grant_wr;
    logic              unused_bits;

    assign unused_bits = ^{addr_rd, wr_rd};

`ifdef FB_RESP_CLEAR_EN
    typedef enum logic {ST_SWEEP, ST_READY} state_t;
    state_t state;
    logic   init_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_SWEEP;
            sweep_idx <= '0;
            init_q    <= 1'b0;
        end else begin
            case (state)
                ST_SWEEP: begin
                    sweep_idx <= sweep_idx + 1'b1;
                    if (sweep_idx == '1) begin
                        state  <= ST_READY;
                        init_q <= 1'b1;
                    end
                end
                ST_READY: state <= ST_READY;
                default:  state <= ST_SWEEP;
            endcase
        end
    end

    assign sweep_we  = (state == ST_SWEEP);
    assign ready     = init_q;
    assign init_done = init_q;
`else
    // Without the sweep the RAM is usable as soon as reset is released.
    assign sweep_we  = 1'b0;
    assign sweep_idx = '0;
    assign ready     = rst_n;
    assign init_done = 1'b1;
`endif

    // Occupancy counts reads already committed to the skid, so it can never overflow.
    assign occ      = OCC_W'(skid_cnt) + OCC_W'(rd_v1) + OCC_W'(rd_v2);
    assign rd_elig  = !addr_empty && ready && (occ < OCC_W'(SKID_DEPTH));
    assign wr_elig  = !wr_empty && ready;
    assign grant_rd = rd_elig && !(wr_elig && (rd_streak == STK_W'(STARVE_LIM)));
    assign grant_wr = wr_elig && !grant_rd;
    assign addr_ren = grant_rd;
    assign wr_ren   = grant_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_v1     <= 1'b0;
            rd_v1     <= 1'b0;
            rd_v2     <= 1'b0;
            rd_streak <= '0;
        end else begin
            wr_v1 <= grant_wr;
            rd_v1 <= grant_rd;
            rd_v2 <= rd_v1;
            if (grant_wr)
                rd_streak <= '0;
            else if (grant_rd && (rd_streak != STK_W'(STARVE_LIM)))
                rd_streak <= rd_streak + 1'b1;
        end
    end

    // FIFO data arrives the cycle after the pop, so the RAM port runs one cycle behind the grant.
    assign ram_we    = sweep_we || wr_v1;
    assign ram_idx   = sweep_we ? sweep_idx :
                       wr_v1    ? wr_rd[DATA_W +: MEM_AW] : addr_rd[MEM_AW-1:0];
    assign ram_wdata = sweep_we ? '0 : wr_rd[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (ram_we)
            mem[ram_idx] <= ram_wdata;
        else if (rd_v1)
            ram_q <= mem[ram_idx];
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rd_v2)
            skid_mem[tail] <= ram_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head     <= '0;
            tail     <= '0;
            skid_cnt <= '0;
        end else begin
            if (rd_v2)
                tail <= ptr_inc(tail);
            if (data_wen)
                head <= ptr_inc(head);
            case ({rd_v2, data_wen})
                2'b10:   skid_cnt <= skid_cnt + 1'b1;
                2'b01:   skid_cnt <= skid_cnt - 1'b1;
                default: skid_cnt <= skid_cnt;
            endcase
        end
    end

    assign data_wen = (skid_cnt != '0) && !data_full;
    assign data_wd  = (skid_cnt != '0) ? skid_mem[head] : '0;

endmodule

// File: tb/tb_fb_responder.sv
// Self-checking bench for fb_responder (MEM_AW=8): directed scenarios plus random traffic
// against a grant-order memory model. Honours FB_RESP_CLEAR_EN when defined.
module tb_fb_responder;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 16;
    localparam int MEM_AW     = 8;
    localparam int SKID_DEPTH = 4;
    localparam int STARVE_LIM = 8;
`ifdef FB_RESP_CLEAR_EN
    localparam bit CLEAR = 1'b1;
`else
    localparam bit CLEAR = 1'b0;
`endif

    logic                     clk;
    logic                     rst_n;
    logic                     wr_ren;
    logic [ADDR_W+DATA_W-1:0] wr_rd;
    logic                     wr_empty;
    logic                     addr_ren;
    logic [ADDR_W-1:0]        addr_rd;
    logic                     addr_empty;
    logic                     data_wen;
    logic [DATA_W-1:0]        data_wd;
    logic                     data_full;
    logic                     init_done;

    fb_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW),
        .SKID_DEPTH(SKID_DEPTH), .STARVE_LIM(STARVE_LIM)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_ren(wr_ren), .wr_rd(wr_rd), .wr_empty(wr_empty),
        .addr_ren(addr_ren), .addr_rd(addr_rd), .addr_empty(addr_empty),
        .data_wen(data_wen), .data_wd(data_wd), .data_full(data_full),
        .init_done(init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int streak = 0;
    int n_rd = 0, n_wr = 0, n_wen = 0;
    int last_rd_cyc = 0, last_wen_cyc = 0;
    logic [15:0] last_wd = '0;

    logic [31:0] wq[$];
    logic [15:0] aq[$];
    logic [15:0] exp_q[$];
    logic [15:0] model_mem [256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_wr(input logic [15:0] a, input logic [15:0] d);
        wq.push_back({a, d});
        wr_empty = 1'b0;
    endtask

    task automatic push_rd(input logic [15:0] a);
        aq.push_back(a);
        addr_empty = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) model_mem[i] = 16'h0000;
    endtask

    // One clock: observe at negedge+1, update the model in grant order, then present FIFO data.
    task automatic tick();
        logic [31:0] pw;
        logic [15:0] pa;
        bit ow, orr;
        pw = '0;
        pa = '0;
        #1;
        ow  = wr_ren;
        orr = addr_ren;
        chk("one_ren", 32'(ow & orr), 32'd0);
        if (!init_done || !rst_n)
            chk("ren_idle", 32'({ow, orr}), 32'd0);
        else if (!wr_empty && (addr_empty || streak >= STARVE_LIM))
            chk("wr_grant", 32'(ow), 32'd1);
        if (orr && !wr_empty)
            chk("starve_lim", 32'(streak < STARVE_LIM), 32'd1);
        if (data_full)
            chk("wen_full", 32'(data_wen), 32'd0);
        if (ow) begin
            if (wq.size() == 0) chk("wr_underflow", 32'd1, 32'd0);
            else begin
                pw = wq.pop_front();
                model_mem[pw[23:16]] = pw[15:0];
                streak = 0;
                n_wr++;
            end
        end
        if (orr) begin
            if (aq.size() == 0) chk("rd_underflow", 32'd1, 32'd0);
            else begin
                pa = aq.pop_front();
                exp_q.push_back(model_mem[pa[7:0]]);
                if (streak < STARVE_LIM) streak++;
                n_rd++;
                last_rd_cyc = cyc;
            end
        end
        if (data_wen) begin
            n_wen++;
            last_wen_cyc = cyc;
            last_wd = data_wd;
            if (exp_q.size() == 0) chk("wen_unexpected", 32'd1, 32'd0);
            else chk("data_wd", 32'(data_wd), 32'(exp_q.pop_front()));
        end
        @(posedge clk);
        #1;
        cyc++;
        if (ow)  wr_rd   = pw;
        if (orr) addr_rd = pa;
        wr_empty   = (wq.size() == 0);
        addr_empty = (aq.size() == 0);
        @(negedge clk);
    endtask

    task automatic run_idle(input int budget, input string tag);
        int k;
        k = 0;
        while ((wq.size() != 0 || aq.size() != 0 || exp_q.size() != 0) && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(k < budget), 32'd1);
        repeat (4) tick();
    endtask

    task automatic wait_sweep(input string tag);
        int k;
        k = 0;
        while (!init_done && k < 400) begin
            tick();
            k++;
        end
        chk(tag, 32'(k), 32'd256);
        clear_model();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, rc, start_rd, start_wen, start_wr, rd_before, first_wen;
        rst_n = 1'b0; wr_empty = 1'b1; addr_empty = 1'b1; data_full = 1'b0;
        wr_rd = '0; addr_rd = '0;
        clear_model();

        // Reset: a pending write must not be popped
        @(negedge clk);
        push_wr(16'h0001, 16'h1111);
        repeat (3) tick();
        chk("rst_wr_ren", 32'(wr_ren), 32'd0);
        chk("rst_addr_ren", 32'(addr_ren), 32'd0);
        chk("rst_data_wen", 32'(data_wen), 32'd0);
        chk("rst_data_wd", 32'(data_wd), 32'd0);
        chk("rst_init_done", 32'(init_done), CLEAR ? 32'd0 : 32'd1);
        rst_n = 1'b1;

        if (CLEAR) begin
            wait_sweep("sweep_len");
            push_rd(16'h0003);
            run_idle(50, "clear_rd_idle");
            chk("clear_rd3", 32'(last_wd), 32'h0000);
        end

        // Preload every RAM word; upper address bits are random and must be ignored
        for (int i = 0; i < 256; i++)
            push_wr({8'($urandom_range(0, 255)), 8'(i)}, 16'($urandom));
        run_idle(600, "preload_idle");

        // Write-then-read latency
        push_wr(16'h0010, 16'hABCD);
        k = 0; start_wr = n_wr;
        while (n_wr == start_wr && k < 10) begin tick(); k++; end
        chk("lat_wr_grant", 32'(n_wr - start_wr), 32'd1);
        push_rd(16'h0010);
        k = 0; start_rd = n_rd;
        while (n_rd == start_rd && k < 10) begin tick(); k++; end
        rc = last_rd_cyc;
        k = 0; start_wen = n_wen;
        while (n_wen == start_wen && k < 10) begin tick(); k++; end
        chk("lat_cycles", 32'(last_wen_cyc - rc), 32'd3);
        chk("lat_data", 32'(last_wd), 32'hABCD);

        // Address aliasing above MEM_AW
        push_wr(16'h0105, 16'h5A5A);
        run_idle(20, "alias_wr_idle");
        push_rd(16'h0005);
        run_idle(20, "alias_rd_idle");
        chk("alias_data", 32'(last_wd), 32'h5A5A);

        // Starvation limit: clear the streak with a lone write first
        push_wr(16'h0020, 16'h2020);
        run_idle(20, "starve_pre_idle");
        for (int i = 0; i < 20; i++) push_rd(16'($urandom));
        push_wr(16'h0030, 16'h3030);
        start_rd = n_rd; start_wr = n_wr; rd_before = -1; k = 0;
        while ((aq.size() != 0 || wq.size() != 0) && k < 100) begin
            tick();
            k++;
            if (rd_before < 0 && n_wr != start_wr) begin
                rd_before = n_rd - start_rd;
                chk("streak_clr", 32'(dut.rd_streak), 32'd0);
            end
        end
        chk("starve_reads", 32'(rd_before), 32'd8);
        run_idle(50, "starve_idle");
        chk("starve_total", 32'(n_rd - start_rd), 32'd20);

        // Back-pressure: only SKID_DEPTH reads issue while full
        data_full = 1'b1;
        for (int i = 0; i < 10; i++) push_rd(16'($urandom));
        start_rd = n_rd; start_wen = n_wen;
        repeat (20) tick();
        chk("bp_reads", 32'(n_rd - start_rd), 32'd4);
        chk("bp_wen", 32'(n_wen - start_wen), 32'd0);
        data_full = 1'b0;
        k = 0; first_wen = -1;
        while ((n_wen - start_wen) < 10 && k < 40) begin
            tick();
            k++;
            if (first_wen < 0 && n_wen != start_wen) first_wen = last_wen_cyc;
        end
        chk("bp_words", 32'(n_wen - start_wen), 32'd10);
        chk("bp_span", 32'(last_wen_cyc - first_wen), 32'd9);

        // Async reset with reads in flight
        push_rd(16'h0011);
        push_rd(16'h0012);
        start_rd = n_rd; k = 0;
        while ((n_rd - start_rd) < 2 && k < 10) begin tick(); k++; end
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_wr_ren", 32'(wr_ren), 32'd0);
        chk("arst_addr_ren", 32'(addr_ren), 32'd0);
        chk("arst_data_wen", 32'(data_wen), 32'd0);
        chk("arst_data_wd", 32'(data_wd), 32'd0);
        chk("arst_init_done", 32'(init_done), CLEAR ? 32'd0 : 32'd1);
        exp_q.delete();
        streak = 0;
        @(negedge clk);
        repeat (3) tick();
        rst_n = 1'b1;
        if (CLEAR) wait_sweep("resweep_len");
        start_wen = n_wen;
        repeat (10) tick();
        chk("arst_no_wen", 32'(n_wen - start_wen), 32'd0);
        push_rd(16'h0012);
        run_idle(20, "arst_rd_idle");
        chk("arst_new_rd", 32'(n_wen - start_wen), 32'd1);

        // Random mixed traffic with random back-pressure
        repeat (400) begin
            if ($urandom_range(0, 99) < 40) push_wr(16'($urandom), 16'($urandom));
            if ($urandom_range(0, 99) < 60) push_rd(16'($urandom));
            data_full = ($urandom_range(0, 99) < 25);
            tick();
        end
        data_full = 1'b0;
        run_idle(1000, "drain_idle");
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
